// File: rtl/pipe_ctrl_pkg.sv
// Shared stall-bus encoding, pipeline stage indices and multi-cycle FSM states
// for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam logic STOP     = 1'b1;
    localparam logic NOT_STOP = 1'b0;

    localparam logic [STALL_W-1:0] STALL_NONE = '0;

    typedef enum logic [2:0] {
        STAGE_WB  = 3'd0,
        STAGE_MEM = 3'd1,
        STAGE_EX  = 3'd2,
        STAGE_ID  = 3'd3,
        STAGE_IF  = 3'd4,
        STAGE_PC  = 3'd5
    } stage_e;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    // Freeze every stage from PC down to 'stage'; the next register down takes the bubble.
    function automatic logic [STALL_W-1:0] stall_from(input stage_e stage);
        logic [STALL_W-1:0] v;
        v = STALL_NONE;
        for (int i = 0; i < STALL_W; i++) begin
            v[i] = (i >= int'(stage)) ? STOP : NOT_STOP;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_mc_seq.sv
// Multi-cycle EX unit sequencer: start/done handshake, timeout watchdog and
// cancel on flush or timeout.
module pipe_ctrl_mc_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_mc_req,
    input  logic mc_done,
    input  logic stallreq_mem,
    input  logic flush,
    output logic ex_stall,
    output logic mc_start,
    output logic mc_cancel,
    output logic mc_err
);

    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    mc_state_e     state;
    logic [TW-1:0] busy_cnt;
    logic          timeout;

    // A late done still wins over the watchdog in the same cycle.
    always_comb begin
        timeout   = (state == MC_BUSY) && !mc_done && (busy_cnt == TW'(MC_TIMEOUT - 1));
        ex_stall  = !rst && ((state == MC_BUSY) || ((state == MC_IDLE) && ex_mc_req));
        mc_start  = !rst && (state == MC_IDLE) && ex_mc_req && !stallreq_mem && !flush;
        mc_cancel = !rst && ((flush && (state != MC_IDLE)) || timeout);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MC_IDLE;
            busy_cnt <= '0;
            mc_err   <= 1'b0;
        end else begin
            if (timeout) begin
                mc_err <= 1'b1;
            end
            if (flush) begin
                state <= MC_IDLE;
            end else begin
                case (state)
                    MC_IDLE: begin
                        if (mc_start) begin
                            state    <= MC_BUSY;
                            busy_cnt <= '0;
                        end
                    end
                    MC_BUSY: begin
                        busy_cnt <= busy_cnt + TW'(1);
                        if (mc_done) begin
                            state <= MC_DONE;
                        end else if (timeout) begin
                            state <= MC_IDLE;
                        end
                    end
                    // Result must stay valid until EX can actually advance.
                    MC_DONE: begin
                        if (!stallreq_mem) begin
                            state <= MC_IDLE;
                        end
                    end
                    default: state <= MC_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: merges ID/EX/MEM stall requests into the
// shared stall vector and counts stalled cycles for performance monitoring.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id_i,
    input  logic               stallreq_mem_i,
    input  logic               ex_mc_req_i,
    input  logic               mc_done_i,
    input  logic               flush_i,
    output logic               mc_start_o,
    output logic               mc_cancel_o,
    output logic               mc_err_o,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    logic ex_stall;

    pipe_ctrl_mc_seq #(
        .MC_TIMEOUT(MC_TIMEOUT)
    ) u_mc_seq (
        .clk         (clk),
        .rst         (rst),
        .ex_mc_req   (ex_mc_req_i),
        .mc_done     (mc_done_i),
        .stallreq_mem(stallreq_mem_i),
        .flush       (flush_i),
        .ex_stall    (ex_stall),
        .mc_start    (mc_start_o),
        .mc_cancel   (mc_cancel_o),
        .mc_err      (mc_err_o)
    );

    // Deepest requesting stage wins: a stall further down must also hold everything above it.
    always_comb begin
        stall_o = STALL_NONE;
        flush_o = 1'b0;
        if (rst) begin
            stall_o = STALL_NONE;
        end else if (flush_i) begin
            flush_o = 1'b1;
        end else if (stallreq_mem_i) begin
            stall_o = stall_from(STAGE_MEM);
        end else if (ex_stall) begin
            stall_o = stall_from(STAGE_EX);
        end else if (stallreq_id_i) begin
            stall_o = stall_from(STAGE_ID);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if ((stall_o != STALL_NONE) && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural reference queues expected
// outputs per driven cycle, a monitor pops and compares them mid-cycle.
module tb_pipe_ctrl;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 5;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    localparam int S_IDLE = 0;
    localparam int S_BUSY = 1;
    localparam int S_DONE = 2;

    logic             clk;
    logic             rst;
    logic             stallreq_id_i;
    logic             stallreq_mem_i;
    logic             ex_mc_req_i;
    logic             mc_done_i;
    logic             flush_i;
    logic             mc_start_o;
    logic             mc_cancel_o;
    logic             mc_err_o;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic [CNT_W-1:0] stall_cnt_o;

    typedef struct packed {
        logic [5:0]       stall;
        logic             flush;
        logic             start;
        logic             cancel;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    string phase = "init";

    int   m_state = S_IDLE;
    int   m_tcnt  = 0;
    logic m_err   = 1'b0;
    int   m_cnt   = 0;

    pipe_ctrl #(
        .MC_TIMEOUT(TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id_i (stallreq_id_i),
        .stallreq_mem_i(stallreq_mem_i),
        .ex_mc_req_i   (ex_mc_req_i),
        .mc_done_i     (mc_done_i),
        .flush_i       (flush_i),
        .mc_start_o    (mc_start_o),
        .mc_cancel_o   (mc_cancel_o),
        .mc_err_o      (mc_err_o),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, queue what the DUT should show,
    // then advance the reference to its post-edge state.
    task automatic applyStimulus(input logic r, input logic id, input logic mem,
                                 input logic req, input logic done, input logic fl);
        exp_t       e;
        logic       ex_st;
        logic       to;
        logic [5:0] sv;
        @(negedge clk);
        rst            = r;
        stallreq_id_i  = id;
        stallreq_mem_i = mem;
        ex_mc_req_i    = req;
        mc_done_i      = done;
        flush_i        = fl;

        ex_st = (m_state == S_BUSY) || ((m_state == S_IDLE) && req);
        if (r || fl)     sv = 6'b000000;
        else if (mem)    sv = 6'b111110;
        else if (ex_st)  sv = 6'b111100;
        else if (id)     sv = 6'b111000;
        else             sv = 6'b000000;
        to = !r && (m_state == S_BUSY) && !done && (m_tcnt == int'(TIMEOUT) - 1);

        e.stall  = sv;
        e.flush  = !r && fl;
        e.start  = !r && (m_state == S_IDLE) && req && !mem && !fl;
        e.cancel = !r && ((fl && (m_state != S_IDLE)) || to);
        e.err    = m_err;
        e.cnt    = CNT_W'(m_cnt);
        exp_q.push_back(e);

        if (r) begin
            m_state = S_IDLE;
            m_tcnt  = 0;
            m_err   = 1'b0;
            m_cnt   = 0;
        end else begin
            if (to) m_err = 1'b1;
            if ((sv != 6'b000000) && (m_cnt < CNT_MAX)) m_cnt++;
            if (fl) begin
                m_state = S_IDLE;
            end else begin
                case (m_state)
                    S_IDLE: if (e.start) begin m_state = S_BUSY; m_tcnt = 0; end
                    S_BUSY: begin
                        m_tcnt++;
                        if (done)    m_state = S_DONE;
                        else if (to) m_state = S_IDLE;
                    end
                    default: if (!mem) m_state = S_IDLE;
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput({phase, ".stall"},  32'(stall_o),     32'(e.stall));
            checkOutput({phase, ".flush"},  32'(flush_o),     32'(e.flush));
            checkOutput({phase, ".start"},  32'(mc_start_o),  32'(e.start));
            checkOutput({phase, ".cancel"}, 32'(mc_cancel_o), 32'(e.cancel));
            checkOutput({phase, ".err"},    32'(mc_err_o),    32'(e.err));
            checkOutput({phase, ".cnt"},    32'(stall_cnt_o), 32'(e.cnt));
        end
    end

    initial begin
        rst            = 1'b1;
        stallreq_id_i  = 1'b0;
        stallreq_mem_i = 1'b0;
        ex_mc_req_i    = 1'b0;
        mc_done_i      = 1'b0;
        flush_i        = 1'b0;

        phase = "reset";
        repeat (2) applyStimulus(1, 1, 1, 1, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        #3 checkOutput("reset_release_stall", 32'(stall_o), 32'h38);

        phase = "divide";
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        #3 checkOutput("divide_start", 32'(mc_start_o), 32'd1);
        for (int c = 1; c <= 7; c++) applyStimulus(0, 0, 0, c <= 6, c == 5, 0);
        #3 checkOutput("divide_stall_cnt", 32'(stall_cnt_o), 32'd6);

        phase = "mem_done";
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        repeat (3) applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        #3 checkOutput("mem_done_no_restart", 32'(mc_start_o), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        #3 checkOutput("mem_done_restart", 32'(mc_start_o), 32'd1);

        phase = "flush";
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 1);
        #3 checkOutput("flush_busy_cancel", 32'(mc_cancel_o), 32'd1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);

        phase = "timeout";
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        for (int c = 1; c <= 8; c++) applyStimulus(0, 0, 0, 0, 0, 0);
        #3 checkOutput("timeout_cancel", 32'(mc_cancel_o), 32'd1);
        repeat (3) applyStimulus(0, 1, 0, 0, 1, 1);
        #3 checkOutput("timeout_err_sticky", 32'(mc_err_o), 32'd1);

        phase = "flush_timeout";
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #3 checkOutput("err_cleared", 32'(mc_err_o), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        for (int c = 1; c <= 7; c++) applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #3 checkOutput("flush_timeout_err", 32'(mc_err_o), 32'd1);

        phase = "priority";
        applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 1, 1, 1, 0, 0);
        #3 checkOutput("priority_mem_stall", 32'(stall_o), 32'h3E);
        applyStimulus(0, 1, 0, 1, 0, 0);
        #3 checkOutput("priority_start", 32'(mc_start_o), 32'd1);

        phase = "done_ignored";
        applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        repeat (2) applyStimulus(0, 0, 1, 0, 1, 0);

        phase = "saturate";
        applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (40) applyStimulus(0, 1, 0, 0, 0, 0);
        #3 checkOutput("cnt_saturated", 32'(stall_cnt_o), 32'(CNT_MAX));

        phase = "random";
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 120; c++) begin
            applyStimulus($urandom_range(0, 31) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 1) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0);
        end

        phase = "drain";
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #4 checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Merges stall requests from ID (load-use), EX (multi-cycle ALU op) and MEM (data-bus wait) into the shared stall vector consumed by every pipeline register, including the EX->MEM latch.
- Sequences the multi-cycle EX unit (divider) through a start/done handshake and owns pipeline flush on exception.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- MC_TIMEOUT, 64, maximum BUSY cycles before mc_err_o is raised.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high (`RstEnable = 1).
- stallreq_id_i  in  1  load-use hazard detected in ID.
- stallreq_mem_i  in  1  data bus not ready in MEM.
- ex_mc_req_i  in  1  EX stage holds a multi-cycle op (div/divu).
- mc_done_i  in  1  multi-cycle unit result valid (single-cycle pulse).
- flush_i  in  1  exception/ertn flush request from MEM.
- mc_start_o  out  1  one-cycle start pulse to the multi-cycle unit.
- mc_cancel_o  out  1  one-cycle abort pulse to the multi-cycle unit.
- mc_err_o  out  1  sticky timeout flag.
- stall_o  out  `StallBus (6)  stall vector; bit5 PC, bit4 IF, bit3 ID, bit2 EX, bit1 MEM, bit0 WB; `Stop = 1.
- flush_o  out  1  clear all pipeline registers this cycle.
- stall_cnt_o  out  CNT_W  cycles with any stall_o bit set, saturating.

Behaviour:
- Reset (rst=1 at posedge clk): FSM = MC_IDLE, timeout counter = 0, mc_err_o = 0, stall_cnt_o = 0. Combinational outputs take their idle values during reset: stall_o = 6'b000000, flush_o = 0, mc_start_o = 0, mc_cancel_o = 0. Reset overrides every other input.
- stall_o is combinational from current inputs and FSM state. Priority, highest first:
  - flush_i: 6'b000000 and flush_o = 1.
  - stallreq_mem_i: 6'b111110.
  - EX stall (ex_stall = state==MC_BUSY, or state==MC_IDLE && ex_mc_req_i): 6'b111100.
  - stallreq_id_i: 6'b111000.
  - Otherwise: 6'b000000.
- Bubble rule for downstream registers: a stage register whose upstream bit is Stop and own bit is NotStop inserts a NOP. The vectors above are contiguous, so exactly one bubble is inserted, at the boundary.
- FSM MC_IDLE:
  - ex_mc_req_i && !stallreq_mem_i && !flush_i: mc_start_o = 1 (combinational, this cycle only); next state MC_BUSY; timeout counter cleared.
  - If stallreq_mem_i is high, no start is issued; stay in MC_IDLE with EX stalled.
- FSM MC_BUSY:
  - Counter increments each cycle.
  - mc_done_i: next state MC_DONE.
  - Counter reaching MC_TIMEOUT-1 without done: set mc_err_o, pulse mc_cancel_o, next state MC_IDLE. The EX stall drops and the op retires with the unit's default result.
- FSM MC_DONE:
  - EX is not stalled by the FSM, so the EX->MEM register captures the result.
  - !stallreq_mem_i: next state MC_IDLE. A new ex_mc_req_i is only honoured from MC_IDLE, so back-to-back divides have a one-cycle gap.
  - stallreq_mem_i: hold MC_DONE, since the result must stay valid until EX advances.
- mc_done_i in MC_IDLE or MC_DONE is ignored.
- flush_i (any state): next state MC_IDLE. If state is MC_BUSY or MC_DONE, mc_cancel_o = 1 for that cycle. No mc_start_o is issued in the flush cycle.
- flush_i and a timeout in the same cycle: a single mc_cancel_o pulse; mc_err_o still sets.
- mc_err_o clears only on reset.
- stall_cnt_o increments when stall_o != 0 and holds at all-ones (no wrap).

Decomposition:
- Shared defines header:
  - `StallBus [5:0]`, `Stop`/`NotStop`.
  - Stage bit indices: PC=5, IF=4, ID=3, EX=2, MEM=1, WB=0.
  - FSM encodings MC_IDLE=2'd0, MC_BUSY=2'd1, MC_DONE=2'd2.
- One sub-module, mc_seq: the multi-cycle FSM plus timeout counter, exporting ex_stall, mc_start, mc_cancel and mc_err. pipe_ctrl keeps the priority encoder and the stall counter.

Test Plan:
- Reset: hold rst 2 cycles with all requests high -> stall_o = 000000, mc_start_o = 0, stall_cnt_o = 0; after release with only stallreq_id_i=1 -> stall_o = 111000.
- Divide: ex_mc_req_i=1 at cycle 0; mc_done_i at cycle 5.
  - Cycle 0: mc_start_o = 1, stall_o = 111100.
  - Cycles 1-5: stall_o = 111100.
  - Cycle 6: MC_DONE, stall_o = 000000.
  - Cycle 7: MC_IDLE.
  - stall_cnt_o = 6.
- MEM stall during MC_DONE: stallreq_mem_i=1 for 3 cycles -> stall_o = 111110, FSM stays MC_DONE; returns to MC_IDLE the cycle after release.
- Flush: flush_i=1 in MC_BUSY -> flush_o = 1, stall_o = 000000, mc_cancel_o = 1 for one cycle; next cycle MC_IDLE.
- Timeout: MC_TIMEOUT=8, mc_done_i never asserted -> mc_cancel_o pulse on the 8th BUSY cycle; mc_err_o = 1 and stays 1 until rst.
- Priority: stallreq_id_i = stallreq_mem_i = ex_mc_req_i = 1 -> stall_o = 111110 and no mc_start_o until stallreq_mem_i drops.
